movavg_ctrl: RTL and testbench

MOVAVG_CTRL -- requirements
Module: movavg_ctrl

---
 rtl/movavg_ctrl.sv | 126 ++++++++++++
 tb/tb_movavg_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/movavg_ctrl.sv
// movavg_ctrl: 4-tap moving-window sum with valid/ready handshake on both sides,
// a one-cycle flush, and a saturating count of delivered sums.
// Optional feature macro: MOVAVG_PRIME_EN. When defined, partial sums are emitted
// while the window is still filling. When undefined, the first sum follows the
// 4th accepted sample after reset or flush.
module movavg_ctrl #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic [1:0]    state,
  output logic [15:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] tap1_q, tap1_d;
  logic [DW-1:0] tap2_q, tap2_d;
  logic [DW-1:0] tap3_q, tap3_d;
  logic [2:0]    fill_q, fill_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [15:0]   count_q, count_d;

  logic          accept;
  logic          deliver;
  logic          emit;
  logic [DW-1:0] sum;

  // A new sample may enter only when the output slot is free or being drained.
  assign in_ready = !reset && !flush && (state_q != S_FLUSH) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid_q && out_ready;
  // Uses the taps before the shift; the adder width drops carries out of DW bits.
  assign sum      = din + tap1_q + tap2_q + tap3_q;

`ifdef MOVAVG_PRIME_EN
  assign emit = 1'b1;
`else
  // Only the accept that completes (or extends) a full window produces a sum.
  assign emit = (fill_q >= 3'd3);
`endif

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign state     = state_q;
  assign count     = count_q;

  // Next-state, window shift and output-slot update.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    tap1_d      = tap1_q;
    tap2_d      = tap2_q;
    tap3_d      = tap3_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    count_d     = count_q;

    if (deliver) begin
      out_valid_d = 1'b0;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end
    end

    if (flush || (state_q == S_FLUSH)) begin
      // Flush wins over any simultaneous sample; a pending sum is dropped.
      state_d     = flush ? S_FLUSH : S_IDLE;
      tap1_d      = '0;
      tap2_d      = '0;
      tap3_d      = '0;
      fill_d      = 3'd0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      tap3_d = tap2_q;
      tap2_d = tap1_q;
      tap1_d = din;
      fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
      if (emit) begin
        out_valid_d = 1'b1;
        dout_d      = sum;
      end
      state_d = (fill_d == 3'd4) ? S_RUN : S_FILL;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= S_IDLE;
      tap1_q      <= '0;
      tap2_q      <= '0;
      tap3_q      <= '0;
      fill_q      <= 3'd0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      tap1_q      <= tap1_d;
      tap2_q      <= tap2_d;
      tap3_q      <= tap3_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_movavg_ctrl.sv
// Self-checking bench for movavg_ctrl. Build with or without MOVAVG_PRIME_EN;
// the expectations follow the same macro.
module tb_movavg_ctrl;

  localparam int DW = 64;

`ifdef MOVAVG_PRIME_EN
  localparam bit PRIME = 1'b1;
  localparam int EXP_RANDOM_COUNT = 1024;
`else
  localparam bit PRIME = 1'b0;
  localparam int EXP_RANDOM_COUNT = 1021;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] din;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic [1:0]    state;
  logic [15:0]   count;

  movavg_ctrl #(.DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .state     (state),
    .count     (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the last three accepted samples, how many samples the
  // window has seen since it was last cleared, and the single output slot.
  logic [DW-1:0] m_hist [3];
  int            m_n;
  logic          m_ov;
  logic [DW-1:0] m_dout;
  int            m_count;
  logic          m_flushing;
  logic          exp_ready;
  logic          obs_ready;

  function automatic logic [1:0] m_state();
    if (m_flushing) return 2'd3;
    if (m_n == 0)   return 2'd0;
    if (m_n < 4)    return 2'd1;
    return 2'd2;
  endfunction

  task automatic model_update(input logic acc, input logic [DW-1:0] d, input logic fl,
                              input logic ordy, input logic rst);
    logic [DW-1:0] s;
    if (rst) begin
      m_hist = '{default: '0};
      m_n = 0; m_ov = 1'b0; m_dout = '0; m_count = 0; m_flushing = 1'b0;
      return;
    end
    if (m_ov && ordy) begin
      if (m_count < 65535) m_count++;
      m_ov = 1'b0;
    end
    if (fl || m_flushing) begin
      m_hist = '{default: '0};
      m_n = 0;
      m_ov = 1'b0;
    end else if (acc) begin
      s = d + m_hist[0] + m_hist[1] + m_hist[2];
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = d;
      if (m_n < 4) m_n++;
      if (PRIME || m_n == 4) begin
        m_ov = 1'b1;
        m_dout = s;
      end
    end
    m_flushing = fl;
  endtask

  // Drive one cycle of inputs, record the handshake, advance the model past the edge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic fl,
                      input logic ordy, input logic rst);
    in_valid = iv; din = d; flush = fl; out_ready = ordy; reset = rst;
    #1;
    exp_ready = !rst && !fl && !m_flushing && (!m_ov || ordy);
    obs_ready = in_ready;
    @(posedge clk);
    model_update(iv && exp_ready, d, fl, ordy, rst);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 64'd5, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", obs_ready); end
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++;
    if (dout !== 64'd0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    checks++;
    if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
  endtask

  task automatic test_ramp();
    logic          ev [5];
    logic [DW-1:0] ed [5];
    logic [1:0]    es [5];
`ifdef MOVAVG_PRIME_EN
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ed = '{64'd1, 64'd3, 64'd6, 64'd10, 64'd14};
`else
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ed = '{64'd0, 64'd0, 64'd0, 64'd10, 64'd14};
`endif
    es = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 64'(i + 1), 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_ready !== 1'b1) begin errors++; $display("FAIL ramp_in_ready[%0d]: got %0b expected 1", i, obs_ready); end
      checks++;
      if (out_valid !== ev[i]) begin errors++; $display("FAIL ramp_valid[%0d]: got %0b expected %0b", i, out_valid, ev[i]); end
      checks++;
      if (dout !== ed[i]) begin errors++; $display("FAIL ramp_dout[%0d]: got %0d expected %0d", i, dout, ed[i]); end
      checks++;
      if (state !== es[i]) begin errors++; $display("FAIL ramp_state[%0d]: got %0d expected %0d", i, state, es[i]); end
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_drain_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 1024; i++) begin
      d = {$urandom, $urandom};
      step(1'b1, d, 1'b0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== m_ov) begin errors++; $display("FAIL rand_valid[%0d]: got %0b expected %0b", i, out_valid, m_ov); end
      if (m_ov) begin
        checks++;
        if (dout !== m_dout) begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", i, dout, m_dout); end
      end
      checks++;
      if (state !== m_state()) begin errors++; $display("FAIL rand_state[%0d]: got %0d expected %0d", i, state, m_state()); end
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 16'(EXP_RANDOM_COUNT)) begin
      errors++; $display("FAIL rand_count: got %0d expected %0d", count, EXP_RANDOM_COUNT);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, {DW{1'b1}}, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %0b expected 1", out_valid); end
    checks++;
    if (dout !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_dout: got %h expected FFFFFFFFFFFFFFFC", dout);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [DW-1:0] held;
    logic [DW-1:0] p;
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    held = m_dout;
    p = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, p, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b expected 0", k, obs_ready); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b expected 1", k, out_valid); end
      checks++;
      if (dout !== held) begin errors++; $display("FAIL stall_dout[%0d]: got %h expected %h", k, dout, held); end
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, p, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_ready !== 1'b1) begin errors++; $display("FAIL resume_in_ready[%0d]: got %0b expected 1", k, obs_ready); end
      checks++;
      if (dout !== m_dout) begin errors++; $display("FAIL resume_dout[%0d]: got %h expected %h", k, dout, m_dout); end
      p = {$urandom, $urandom};
    end
    checks++;
    if (count !== 16'(m_count)) begin errors++; $display("FAIL resume_count: got %0d expected %0d", count, m_count); end
  endtask

  task automatic test_flush();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    step(1'b1, 64'd99, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %0b expected 0", obs_ready); end
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL flush_state: got %0d expected 3", state); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b expected 0", out_valid); end
    checks++;
    if (count !== 16'(m_count)) begin errors++; $display("FAIL flush_count: got %0d expected %0d", count, m_count); end
    step(1'b1, 64'd7, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle_in_ready: got %0b expected 0", obs_ready); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL flush_idle: got %0d expected 0", state); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 64'd7, 1'b0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== m_ov) begin errors++; $display("FAIL refill_valid[%0d]: got %0b expected %0b", i, out_valid, m_ov); end
    end
    checks++;
    if (dout !== 64'd28) begin errors++; $display("FAIL refill_dout: got %0d expected 28", dout); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    step(1'b1, 64'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'd3, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %0b expected 0", obs_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b expected 0", out_valid); end
    checks++;
    if (count !== 16'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", state); end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after_valid: got %0b expected 0", out_valid); end
  endtask

  initial begin
    in_valid = 1'b0; din = '0; flush = 1'b0; out_ready = 1'b0; reset = 1'b1;
    m_hist = '{default: '0};
    m_n = 0; m_ov = 1'b0; m_dout = '0; m_count = 0; m_flushing = 1'b0;
    test_reset();
    test_ramp();
    test_random();
    test_wrap();
    test_back_to_back_stall();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
